// File: rtl/clk_divider_pkg.sv
// Shared constants and helpers for the DDS clock divider.
// Build option: CLK_DIVIDER_ODD_DUTY_EN selects 50 % duty for odd divide ratios.
package clk_divider_pkg;

  localparam int PLL_FREQ_HZ = 48_000_000;
  localparam int FG_DIV_DEF  = 48;
  localparam int DAC_DIV_DEF = 2;

  // Width of a counter that walks 0..n-1; at least one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_cell.sv
// Purpose: divide-by-N registered clock cell; latency: first high on first enabled edge.
// Backpressure: none. CLK_DIVIDER_ODD_DUTY_EN adds a falling-edge stage for odd N.
module clk_div_cell
  import clk_divider_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic clk_out
);

  localparam int W = cnt_width(N);
  localparam int H = N / 2;
  localparam logic [W-1:0] CNT_LAST = W'(N - 1);
  localparam logic [W-1:0] CNT_HALF = W'(H);

  generate
    if (N < 2) begin : g_bad_n
      $error("clk_div_cell: divide ratio N must be >= 2");
    end
  endgenerate

  logic [W-1:0] cnt;
  logic         out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      out_q <= 1'b0;
    end else if (en) begin
      out_q <= (cnt < CNT_HALF);
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

`ifdef CLK_DIVIDER_ODD_DUTY_EN
  generate
    if ((N % 2) == 1) begin : g_odd_duty
      // Half-cycle extension of the high phase: stretches H cycles to N/2.
      logic q_neg;

      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_neg <= 1'b0;
        end else begin
          q_neg <= out_q;
        end
      end

      assign clk_out = out_q | q_neg;
    end else begin : g_even
      assign clk_out = out_q;
    end
  endgenerate
`else
  assign clk_out = out_q;
`endif

endmodule

// File: rtl/clk_divider.sv
// Purpose: derive Fg_CLK and Dac_CLK from PLL_CLK; first rising edge on 3rd PLL edge after reset release.
// Backpressure: none. Odd-ratio duty controlled by CLK_DIVIDER_ODD_DUTY_EN.
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int FG_DIV  = FG_DIV_DEF,
  parameter int DAC_DIV = DAC_DIV_DEF
) (
  input  logic PLL_CLK,
  input  logic RESETn,
  output logic Fg_CLK,
  output logic Dac_CLK
);

  // Async assert, sync deassert; both cells start on the same edge.
  logic [1:0] rst_sync_q;
  logic       div_en;

  always_ff @(posedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign div_en = rst_sync_q[1];

  clk_div_cell #(
    .N (FG_DIV)
  ) u_fg_div (
    .clk     (PLL_CLK),
    .rst_n   (RESETn),
    .en      (div_en),
    .clk_out (Fg_CLK)
  );

  clk_div_cell #(
    .N (DAC_DIV)
  ) u_dac_div (
    .clk     (PLL_CLK),
    .rst_n   (RESETn),
    .en      (div_en),
    .clk_out (Dac_CLK)
  );

endmodule

// File: tb/tb_clk_divider.sv
// Bench for clk_divider: default ratios (48/2) plus an odd-ratio instance (5/3).
`timescale 1ps/1ps
module tb_clk_divider;

  localparam int HALF_A = 10416;
  localparam int HALF_B = 10417;
  localparam int PER    = HALF_A + HALF_B;
  localparam int FG1    = 48;
  localparam int DAC1   = 2;
  localparam int FG2    = 5;
  localparam int DAC2   = 3;

  logic PLL_CLK_tb = 1'b0;
  logic RESETn     = 1'b1;
  logic fg1, dac1, fg2, dac2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic fg1;
    logic dac1;
    logic fg2;
    logic dac2;
  } exp_t;

  exp_t sb_q[$];

  clk_divider #(.FG_DIV(FG1), .DAC_DIV(DAC1)) dut (
    .PLL_CLK (PLL_CLK_tb),
    .RESETn  (RESETn),
    .Fg_CLK  (fg1),
    .Dac_CLK (dac1)
  );

  clk_divider #(.FG_DIV(FG2), .DAC_DIV(DAC2)) dut_odd (
    .PLL_CLK (PLL_CLK_tb),
    .RESETn  (RESETn),
    .Fg_CLK  (fg2),
    .Dac_CLK (dac2)
  );

  always begin
    #HALF_A PLL_CLK_tb = 1'b1;
    #HALF_B PLL_CLK_tb = 1'b0;
  end

  // Expected level sampled just after the k-th rising edge following release.
  function automatic logic div_exp(input int k, input int n);
    if (k < 3) return 1'b0;
    return ((k - 3) % n) < (n / 2);
  endfunction

  function automatic logic div_view(input int k, input int n);
`ifdef CLK_DIVIDER_ODD_DUTY_EN
    if ((n % 2) == 1) return div_exp(k, n) | div_exp(k - 1, n);
`endif
    return div_exp(k, n);
  endfunction

  task automatic test_reset();
    #1 RESETn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(PLL_CLK_tb);
      #1;
      n_cmp++;
      if ({fg1, dac1, fg2, dac2} !== 4'b0000) begin
        n_bad++;
        $display("FAIL reset_hold half=%0d got=%b exp=0000", i, {fg1, dac1, fg2, dac2});
      end
    end
  endtask

  // Releases reset 10 ps after a rising edge and scoreboards ncyc rising edges.
  task automatic track(input string tag, input int ncyc);
    exp_t e;
    logic pf, pd, fg_seen, dac_seen;
    time  t_fr, t_dr;
    logic have_fr, have_dr;
    pf = 1'b0; pd = 1'b0; fg_seen = 1'b0; dac_seen = 1'b0;
    have_fr = 1'b0; have_dr = 1'b0; t_fr = 0; t_dr = 0;
    @(posedge PLL_CLK_tb);
    #10 RESETn = 1'b1;
    #1;
    n_cmp++;
    if ({fg1, dac1, fg2, dac2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s release_runt got=%b exp=0000", tag, {fg1, dac1, fg2, dac2});
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge PLL_CLK_tb);
      sb_q.push_back('{fg1: div_view(k, FG1), dac1: div_view(k, DAC1),
                       fg2: div_view(k, FG2), dac2: div_view(k, DAC2)});
      #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (fg1 !== e.fg1) begin
        n_bad++;
        $display("FAIL %s fg edge=%0d got=%b exp=%b", tag, k, fg1, e.fg1);
      end
      n_cmp++;
      if (dac1 !== e.dac1) begin
        n_bad++;
        $display("FAIL %s dac edge=%0d got=%b exp=%b", tag, k, dac1, e.dac1);
      end
      n_cmp++;
      if (fg2 !== e.fg2) begin
        n_bad++;
        $display("FAIL %s fg_odd edge=%0d got=%b exp=%b", tag, k, fg2, e.fg2);
      end
      n_cmp++;
      if (dac2 !== e.dac2) begin
        n_bad++;
        $display("FAIL %s dac_odd edge=%0d got=%b exp=%b", tag, k, dac2, e.dac2);
      end
      if (fg1 && !pf) begin
        n_cmp++;
        if (!(dac1 && !pd)) begin
          n_bad++;
          $display("FAIL %s align edge=%0d dac_prev=%b dac_now=%b exp=rise", tag, k, pd, dac1);
        end
        if (!fg_seen) begin
          n_cmp++;
          if (k != 3) begin
            n_bad++;
            $display("FAIL %s fg_first_edge got=%0d exp=3", tag, k);
          end
          fg_seen = 1'b1;
        end
        if (have_fr) begin
          n_cmp++;
          if (($time - 1 - t_fr) != FG1 * PER) begin
            n_bad++;
            $display("FAIL %s fg_period got=%0t exp=%0d", tag, $time - 1 - t_fr, FG1 * PER);
          end
        end
        t_fr = $time - 1; have_fr = 1'b1;
      end
      if (!fg1 && pf) begin
        n_cmp++;
        if (($time - 1 - t_fr) != (FG1 / 2) * PER) begin
          n_bad++;
          $display("FAIL %s fg_high got=%0t exp=%0d", tag, $time - 1 - t_fr, (FG1 / 2) * PER);
        end
      end
      if (dac1 && !pd) begin
        if (!dac_seen) begin
          n_cmp++;
          if (k != 3) begin
            n_bad++;
            $display("FAIL %s dac_first_edge got=%0d exp=3", tag, k);
          end
          dac_seen = 1'b1;
        end
        if (have_dr) begin
          n_cmp++;
          if (($time - 1 - t_dr) != DAC1 * PER) begin
            n_bad++;
            $display("FAIL %s dac_period got=%0t exp=%0d", tag, $time - 1 - t_dr, DAC1 * PER);
          end
        end
        t_dr = $time - 1; have_dr = 1'b1;
      end
      pf = fg1;
      pd = dac1;
    end
  endtask

  task automatic test_steady();
    track("steady", 5000);
  endtask

  task automatic test_mid_reset();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge PLL_CLK_tb);
      #1;
      if (fg1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL mid_reset_wait got=timeout exp=fg_high");
    end
    #2000 RESETn = 1'b0;
    #1;
    n_cmp++;
    if ({fg1, dac1, fg2, dac2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset_drop got=%b exp=0000", {fg1, dac1, fg2, dac2});
    end
    #100000;
    n_cmp++;
    if ({fg1, dac1, fg2, dac2} !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_reset_hold got=%b exp=0000", {fg1, dac1, fg2, dac2});
    end
    track("restart", 200);
  endtask

  // Run lengths of the odd-ratio output measured in half PLL periods.
  task automatic test_odd_divider();
    int   run_len, runs;
    logic prev, synced;
    int   exp_hi, exp_lo;
`ifdef CLK_DIVIDER_ODD_DUTY_EN
    exp_hi = FG2; exp_lo = FG2;
`else
    exp_hi = 2 * (FG2 / 2); exp_lo = 2 * (FG2 - FG2 / 2);
`endif
    run_len = 0; runs = 0; synced = 1'b0;
    @(PLL_CLK_tb);
    #1 prev = fg2;
    for (int i = 0; i < 80; i++) begin
      @(PLL_CLK_tb);
      #1;
      if (fg2 === prev) begin
        run_len++;
      end else begin
        run_len++;
        if (synced) begin
          runs++;
          n_cmp++;
          if (run_len != (prev ? exp_hi : exp_lo)) begin
            n_bad++;
            $display("FAIL odd_run level=%b got=%0d exp=%0d halfs", prev, run_len,
                     prev ? exp_hi : exp_lo);
          end
        end
        synced  = 1'b1;
        run_len = 0;
        prev    = fg2;
      end
    end
    n_cmp++;
    if (runs < 10) begin
      n_bad++;
      $display("FAIL odd_run_count got=%0d exp>=10", runs);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_odd_divider();
    test_mid_reset();
    test_odd_divider();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
